// File: rtl/sim_chk_pkg.sv
// Shared types for the commit checker that drives the sim_intf co-simulation port.
// Holds the retire-entry layout, error kinds, FSM states and the idle PC.
package sim_chk_pkg;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
    } retire_entry_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_PC_MISS = 2'd1,
        ERR_INSN    = 2'd2,
        ERR_BOTH    = 2'd3
    } err_kind_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        HALT  = 2'd3
    } chk_state_e;

    localparam logic [63:0] SIM_IDLE_PC = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// Retire buffer: synchronous FIFO of retire entries with a one-deep peek past the head.
// A push into a full FIFO is dropped even when a pop happens in the same cycle.
module commit_fifo
    import sim_chk_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  retire_entry_t             wdata,
    output retire_entry_t             head,
    output retire_entry_t             head_next,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    retire_entry_t   mem_r [DEPTH];
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW:0]     count_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];
    assign head_next = mem_r[rd_ptr_r + AW'(1)];

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
        end
    end

endmodule

// File: rtl/commit_checker.sv
// Buffers retired instructions and steps sim_intf exactly once per retirement,
// checking PC/instruction agreement and logging, counting and halting on errors.
module commit_checker
    import sim_chk_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [63:0] IDLE_PC    = SIM_IDLE_PC,
    parameter int unsigned MAX_ERR    = 1,
    parameter bit          CHECK_INSN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ret_valid,
    output logic        ret_ready,
    input  logic [63:0] ret_pc,
    input  logic [31:0] ret_insn,
    output logic [63:0] next_pc_check,
    input  logic [63:0] next_pc,
    input  logic [31:0] next_insn,
    input  logic        miss,
    output logic        err_valid,
    output logic [1:0]  err_kind,
    output logic [63:0] err_dut_pc,
    output logic [63:0] err_ref_pc,
    output logic [31:0] chk_count,
    output logic [31:0] err_count,
    output logic        halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    chk_state_e     state_r;
    logic [63:0]    next_pc_check_r;
    logic           ret_ready_r;
    logic           err_valid_r;
    err_kind_e      err_kind_r;
    logic [63:0]    err_dut_pc_r;
    logic [63:0]    err_ref_pc_r;
    logic [31:0]    chk_count_r;
    logic [31:0]    err_count_r;
    logic           halted_r;
    logic [31:0]    exp_insn_r;
    logic           exp_insn_valid_r;

    retire_entry_t  head_s;
    retire_entry_t  head_next_s;
    logic           full_s;
    logic           empty_s;
    logic [CW-1:0]  count_s;
    logic           push_s;
    logic           pop_s;
    logic           pc_err_s;
    logic           insn_err_s;
    logic           err_s;
    logic [31:0]    err_inc_s;
    logic           halt_go_s;
    logic           more_s;
    logic [63:0]    follow_pc_s;
    logic [CW-1:0]  count_next_s;
    logic           ready_next_s;

    assign push_s = ret_valid && ret_ready_r;
    assign pop_s  = (state_r == RESP);

    commit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .wdata     ('{pc: ret_pc, insn: ret_insn}),
        .head      (head_s),
        .head_next (head_next_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Response evaluation and next-entry selection; a push landing while only the
    // head is queued is forwarded straight from the retire port.
    always_comb begin
        pc_err_s     = miss;
        insn_err_s   = CHECK_INSN && exp_insn_valid_r && (head_s.insn != exp_insn_r);
        err_s        = pc_err_s || insn_err_s;
        err_inc_s    = err_s ? sat_inc32(err_count_r) : err_count_r;
        halt_go_s    = pop_s && (MAX_ERR != 32'd0) && (err_inc_s >= 32'(MAX_ERR));
        more_s       = (count_s > CW'(1)) || push_s;
        count_next_s = count_s + CW'(push_s) - CW'(pop_s);
        if (count_s > CW'(1)) begin
            follow_pc_s = head_next_s.pc;
        end else begin
            follow_pc_s = ret_pc;
        end
        ready_next_s = (count_next_s != CW'(FIFO_DEPTH)) && !halted_r && !halt_go_s;
    end

    // Checker FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            next_pc_check_r  <= IDLE_PC;
            ret_ready_r      <= 1'b0;
            err_valid_r      <= 1'b0;
            err_kind_r       <= ERR_NONE;
            err_dut_pc_r     <= 64'd0;
            err_ref_pc_r     <= 64'd0;
            chk_count_r      <= 32'd0;
            err_count_r      <= 32'd0;
            halted_r         <= 1'b0;
            exp_insn_r       <= 32'd0;
            exp_insn_valid_r <= 1'b0;
        end else begin
            err_valid_r <= 1'b0;
            ret_ready_r <= ready_next_s;
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        state_r         <= ISSUE;
                        next_pc_check_r <= head_s.pc;
                    end else begin
                        next_pc_check_r <= IDLE_PC;
                    end
                end
                ISSUE: begin
                    state_r         <= RESP;
                    next_pc_check_r <= IDLE_PC;
                end
                RESP: begin
                    chk_count_r      <= sat_inc32(chk_count_r);
                    exp_insn_r       <= next_insn;
                    exp_insn_valid_r <= 1'b1;
                    if (err_s) begin
                        err_valid_r  <= 1'b1;
                        err_kind_r   <= err_kind_e'({insn_err_s, pc_err_s});
                        err_dut_pc_r <= head_s.pc;
                        err_ref_pc_r <= next_pc;
                        err_count_r  <= err_inc_s;
                    end
                    if (halt_go_s) begin
                        state_r         <= HALT;
                        halted_r        <= 1'b1;
                        next_pc_check_r <= IDLE_PC;
                    end else if (more_s) begin
                        state_r         <= ISSUE;
                        next_pc_check_r <= follow_pc_s;
                    end else begin
                        state_r         <= IDLE;
                        next_pc_check_r <= IDLE_PC;
                    end
                end
                HALT: begin
                    halted_r        <= 1'b1;
                    next_pc_check_r <= IDLE_PC;
                end
                default: begin
                    state_r         <= IDLE;
                    next_pc_check_r <= IDLE_PC;
                end
            endcase
        end
    end

    assign ret_ready     = ret_ready_r;
    assign next_pc_check = next_pc_check_r;
    assign err_valid     = err_valid_r;
    assign err_kind      = err_kind_r;
    assign err_dut_pc    = err_dut_pc_r;
    assign err_ref_pc    = err_ref_pc_r;
    assign chk_count     = chk_count_r;
    assign err_count     = err_count_r;
    assign halted        = halted_r;

endmodule

// File: tb/tb_commit_checker.sv
// Directed bench for commit_checker: three configurations, each paired with a small
// sim_intf reference model that steps on a matching next_pc_check.
module tb_commit_checker;
    import sim_chk_pkg::*;

    localparam logic [63:0] IDLE = SIM_IDLE_PC;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0010_0093;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rv [3];
    logic [63:0] rpc [3];
    logic [31:0] rinsn [3];
    logic        rdy [3];
    logic [63:0] npc [3];
    logic [63:0] mpc [3];
    logic [31:0] minsn [3];
    logic        mmiss [3];
    logic        ev [3];
    logic [1:0]  ek [3];
    logic [63:0] edpc [3];
    logic [63:0] erpc [3];
    logic [31:0] cc [3];
    logic [31:0] ec [3];
    logic        hl [3];
    int          midx [3];

    int n_checks = 0;
    int n_fail = 0;

    commit_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .ret_valid(rv[0]), .ret_ready(rdy[0]), .ret_pc(rpc[0]),
        .ret_insn(rinsn[0]), .next_pc_check(npc[0]), .next_pc(mpc[0]), .next_insn(minsn[0]),
        .miss(mmiss[0]), .err_valid(ev[0]), .err_kind(ek[0]), .err_dut_pc(edpc[0]),
        .err_ref_pc(erpc[0]), .chk_count(cc[0]), .err_count(ec[0]), .halted(hl[0]));

    commit_checker #(.MAX_ERR(0), .CHECK_INSN(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ret_valid(rv[1]), .ret_ready(rdy[1]), .ret_pc(rpc[1]),
        .ret_insn(rinsn[1]), .next_pc_check(npc[1]), .next_pc(mpc[1]), .next_insn(minsn[1]),
        .miss(mmiss[1]), .err_valid(ev[1]), .err_kind(ek[1]), .err_dut_pc(edpc[1]),
        .err_ref_pc(erpc[1]), .chk_count(cc[1]), .err_count(ec[1]), .halted(hl[1]));

    commit_checker #(.FIFO_DEPTH(2), .MAX_ERR(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ret_valid(rv[2]), .ret_ready(rdy[2]), .ret_pc(rpc[2]),
        .ret_insn(rinsn[2]), .next_pc_check(npc[2]), .next_pc(mpc[2]), .next_insn(minsn[2]),
        .miss(mmiss[2]), .err_valid(ev[2]), .err_kind(ek[2]), .err_dut_pc(edpc[2]),
        .err_ref_pc(erpc[2]), .chk_count(cc[2]), .err_count(ec[2]), .halted(hl[2]));

    // Reference model: the expected PC walks BASE, BASE+4, ...; every word is a NOP.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                midx[k]  <= 0;
                mmiss[k] <= 1'b0;
            end else if (npc[k] != IDLE) begin
                if (npc[k] == BASE + 64'(4 * midx[k])) begin
                    midx[k]  <= midx[k] + 1;
                    mmiss[k] <= 1'b0;
                end else begin
                    mmiss[k] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            mpc[k]   = BASE + 64'(4 * midx[k]);
            minsn[k] = NOP;
        end
    end

    // Protocol monitor: issues never back to back, error pulses one cycle wide.
    int          viol = 0;
    int          issues [3] = '{0, 0, 0};
    int          pulses [3] = '{0, 0, 0};
    logic        prev_iss [3] = '{1'b0, 1'b0, 1'b0};
    logic        prev_ev [3] = '{1'b0, 1'b0, 1'b0};
    logic [1:0]  last_k [3];
    logic [63:0] last_d [3];
    logic [63:0] last_r [3];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (npc[k] != IDLE) begin
                issues[k] <= issues[k] + 1;
                if (prev_iss[k]) viol <= viol + 1;
            end
            prev_iss[k] <= (npc[k] != IDLE);
            if (ev[k]) begin
                pulses[k] <= pulses[k] + 1;
                last_k[k] <= ek[k];
                last_d[k] <= edpc[k];
                last_r[k] <= erpc[k];
                if (prev_ev[k]) viol <= viol + 1;
            end
            prev_ev[k] <= ev[k];
        end
    end

    // Acceptance tracking for the depth-2 instance.
    int   acc2 = 0;
    int   acc_at_drop = -1;
    logic drop_seen = 1'b0;

    always @(posedge clk) begin
        if (rv[2]) begin
            if (rdy[2]) begin
                acc2 <= acc2 + 1;
            end else if (!drop_seen) begin
                drop_seen   <= 1'b1;
                acc_at_drop <= acc2;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int k, input logic [63:0] pc, input logic [31:0] insn);
        int n = 0;
        rv[k] = 1'b1;
        rpc[k] = pc;
        rinsn[k] = insn;
        while (!rdy[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("push_ready", 64'(rdy[k]), 64'd1);
        @(negedge clk);
        rv[k] = 1'b0;
    endtask

    task automatic wait_chk(input int k, input logic [31:0] target);
        int n = 0;
        while (cc[k] != target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_chk", 64'(cc[k]), 64'(target));
        @(negedge clk);
    endtask

    int iss_before;

    initial begin
        for (int k = 0; k < 3; k++) begin
            rv[k] = 1'b0;
            rpc[k] = 64'd0;
            rinsn[k] = 32'd0;
        end
        repeat (2) @(negedge clk);
        check_val("rst_npc", npc[0], IDLE);
        check_val("rst_ready", 64'(rdy[0]), 64'd0);
        check_val("rst_ev", 64'(ev[0]), 64'd0);
        check_val("rst_kind", 64'(ek[0]), 64'd0);
        check_val("rst_dpc", edpc[0], 64'd0);
        check_val("rst_rpc", erpc[0], 64'd0);
        check_val("rst_chk", 64'(cc[0]), 64'd0);
        check_val("rst_err", 64'(ec[0]), 64'd0);
        check_val("rst_halt", 64'(hl[0]), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Three matching retires.
        for (int i = 0; i < 3; i++) push(0, BASE + 64'(4 * i), NOP);
        wait_chk(0, 32'd3);
        check_val("match_err", 64'(ec[0]), 64'd0);
        check_val("match_pulses", 64'(pulses[0]), 64'd0);

        // Instruction mismatch ignored when the compare is disabled.
        push(1, BASE, NOP);
        push(1, BASE + 64'd4, ADDI);
        wait_chk(1, 32'd2);
        check_val("noinsn_err", 64'(ec[1]), 64'd0);
        check_val("noinsn_pulses", 64'(pulses[1]), 64'd0);

        // PC miss halts with MAX_ERR=1.
        push(0, 64'h8000_0010, NOP);
        wait_chk(0, 32'd4);
        check_val("miss_pulses", 64'(pulses[0]), 64'd1);
        check_val("miss_kind", 64'(last_k[0]), 64'd1);
        check_val("miss_dpc", last_d[0], 64'h8000_0010);
        check_val("miss_rpc", last_r[0], 64'h8000_000C);
        check_val("miss_errcnt", 64'(ec[0]), 64'd1);
        check_val("miss_halted", 64'(hl[0]), 64'd1);
        check_val("miss_ready", 64'(rdy[0]), 64'd0);

        // Five misses without halting, then a matching retire.
        for (int i = 0; i < 5; i++) push(1, 64'h9000_0000 + 64'(4 * i), NOP);
        wait_chk(1, 32'd7);
        check_val("nohalt_err", 64'(ec[1]), 64'd5);
        check_val("nohalt_pulses", 64'(pulses[1]), 64'd5);
        check_val("nohalt_kind", 64'(last_k[1]), 64'd1);
        check_val("nohalt_halted", 64'(hl[1]), 64'd0);
        push(1, BASE + 64'd8, NOP);
        wait_chk(1, 32'd8);
        check_val("nohalt_after", 64'(ec[1]), 64'd5);

        // Burst of ten into a two-entry buffer.
        for (int i = 0; i < 10; i++) push(2, BASE + 64'(4 * i), NOP);
        wait_chk(2, 32'd10);
        check_val("burst_drop_seen", 64'(drop_seen), 64'd1);
        check_val("burst_drop_at", 64'(acc_at_drop), 64'd2);
        check_val("burst_acc", 64'(acc2), 64'd10);
        check_val("burst_err", 64'(ec[2]), 64'd0);

        // Reset clears the halt.
        rst_n = 1'b0;
        #1;
        check_val("rst2_halt", 64'(hl[0]), 64'd0);
        check_val("rst2_chk", 64'(cc[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during RESP with entries still queued.
        for (int i = 0; i < 6; i++) push(0, BASE + 64'(4 * i), NOP);
        for (int n = 0; n < 50 && npc[0] == IDLE; n++) @(negedge clk);
        check_val("mid_issue", 64'(npc[0] != IDLE), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_npc", npc[0], IDLE);
        check_val("mid_ready", 64'(rdy[0]), 64'd0);
        check_val("mid_chk", 64'(cc[0]), 64'd0);
        check_val("mid_ev", 64'(ev[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        iss_before = issues[0];
        repeat (10) @(negedge clk);
        check_val("mid_flushed", 64'(issues[0] - iss_before), 64'd0);
        check_val("mid_chk_after", 64'(cc[0]), 64'd0);

        // Instruction mismatch on the second check after reset.
        push(0, BASE, NOP);
        push(0, BASE + 64'd4, ADDI);
        wait_chk(0, 32'd2);
        check_val("insn_pulses", 64'(pulses[0]), 64'd2);
        check_val("insn_kind", 64'(last_k[0]), 64'd2);
        check_val("insn_dpc", last_d[0], BASE + 64'd4);
        check_val("insn_rpc", last_r[0], BASE + 64'd8);
        check_val("insn_halted", 64'(hl[0]), 64'd1);
        check_val("insn_errcnt", 64'(ec[0]), 64'd1);

        check_val("protocol_viol", 64'(viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
